// File: rtl/video_out_if.sv
// Renderer/CPU-facing bus of the palette output stage: pixel strobes, plex,
// palette write port and the RGB/blank result.
interface video_out_if;
  logic        stb_lo;
  logic        stb_hi;
  logic [7:0]  vplex_in;
  logic        hires;
  logic [3:0]  palsel;
  logic        blank;
  logic        cram_we;
  logic [7:0]  cram_addr;
  logic [14:0] cram_data;
  logic [4:0]  vred;
  logic [4:0]  vgrn;
  logic [4:0]  vblu;
  logic        vsync_blank;

  modport master (
    output stb_lo, stb_hi, vplex_in, hires, palsel, blank,
    output cram_we, cram_addr, cram_data,
    input  vred, vgrn, vblu, vsync_blank
  );

  modport slave (
    input  stb_lo, stb_hi, vplex_in, hires, palsel, blank,
    input  cram_we, cram_addr, cram_data,
    output vred, vgrn, vblu, vsync_blank
  );
endinterface

// File: rtl/video_out.sv
// Palette output stage: plex -> index -> 256x15 CRAM -> blanked, registered RGB.
// Optional VOUT_PALLOCK_EN defers CPU palette writes until the display is blanked.
module video_out #(
  parameter int unsigned LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  video_out_if.slave  vif
);
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned COL_W   = 15;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned ADV_W   = LAT - 1;

  logic [COL_W-1:0] cram [DEPTH];

  logic [IDX_W-1:0] plex_l;
  logic [IDX_W-1:0] idx_q;
  logic             blank0_q;
  logic             ok0_q;
  logic [ADV_W-1:0] adv_q;
  logic             blank1_q;
  logic [COL_W-1:0] rdata_q;
  logic [COL_W-1:0] rgb_q;
  logic             vsb_q;

  logic             strobe_c;
  logic [3:0]       nib_c;
  logic [IDX_W-1:0] idx_c;

  logic             mem_we_c;
  logic [IDX_W-1:0] mem_addr_c;
  logic [COL_W-1:0] mem_data_c;

  // Stage-0 index: upper nibble of fresh plex at stb_lo, lower nibble of latched plex at stb_hi
  always_comb begin
    strobe_c = vif.stb_lo | vif.stb_hi;
    nib_c    = vif.stb_lo ? vif.vplex_in[7:4] : plex_l[3:0];
    idx_c    = vif.stb_lo ? vif.vplex_in : plex_l;
    if (vif.hires) begin
      idx_c = {vif.palsel, nib_c};
    end
  end

  // Pipeline only advances behind a strobe so outputs hold between pixels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plex_l   <= '0;
      idx_q    <= '0;
      blank0_q <= 1'b1;
      ok0_q    <= 1'b0;
      adv_q    <= '0;
      blank1_q <= 1'b1;
      rdata_q  <= '0;
      rgb_q    <= '0;
      vsb_q    <= 1'b1;
    end else begin
      adv_q <= {adv_q[ADV_W-2:0], strobe_c};
      if (vif.stb_lo) begin
        plex_l <= vif.vplex_in;
        ok0_q  <= 1'b1;
      end
      if (strobe_c) begin
        idx_q    <= idx_c;
        blank0_q <= vif.blank;
      end
      if (adv_q[0]) begin
        rdata_q  <= cram[idx_q];
        blank1_q <= blank0_q | ~ok0_q;
      end
      if (adv_q[ADV_W-1]) begin
        rgb_q <= blank1_q ? COL_W'(0) : rdata_q;
        vsb_q <= blank1_q;
      end
    end
  end

`ifdef VOUT_PALLOCK_EN
  logic             pend_v_q;
  logic [IDX_W-1:0] pend_a_q;
  logic [COL_W-1:0] pend_d_q;

  // A live write during blank wins the port; the pending entry drains on a later blank cycle
  always_comb begin
    mem_we_c   = 1'b0;
    mem_addr_c = pend_a_q;
    mem_data_c = pend_d_q;
    if (vif.cram_we && blank0_q) begin
      mem_we_c   = 1'b1;
      mem_addr_c = vif.cram_addr;
      mem_data_c = vif.cram_data;
    end else if (pend_v_q && blank0_q) begin
      mem_we_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      pend_d_q <= '0;
    end else if (vif.cram_we && !blank0_q) begin
      pend_v_q <= 1'b1;
      pend_a_q <= vif.cram_addr;
      pend_d_q <= vif.cram_data;
    end else if (vif.cram_we) begin
      if (pend_v_q && (pend_a_q == vif.cram_addr)) begin
        pend_v_q <= 1'b0;
      end
    end else if (pend_v_q && blank0_q) begin
      pend_v_q <= 1'b0;
    end
  end
`else
  always_comb begin
    mem_we_c   = vif.cram_we;
    mem_addr_c = vif.cram_addr;
    mem_data_c = vif.cram_data;
  end
`endif

  // CRAM is not reset; reads above see pre-write contents on a same-edge write
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      cram[mem_addr_c] <= mem_data_c;
    end
  end

  assign vif.vred        = rgb_q[14:10];
  assign vif.vgrn        = rgb_q[9:5];
  assign vif.vblu        = rgb_q[4:0];
  assign vif.vsync_blank = vsb_q;

endmodule
